// File: rtl/calculator_core_if.sv
// Button/slider inputs and display outputs of the calculator core, bundled as one interface.
interface calculator_core_if;
    logic        button_clr;
    logic        button_ent;
    logic        button_add;
    logic        button_sub;
    logic        slider_1;
    logic        slider_2;
    logic        slider_3;
    logic        slider_4;
    logic [15:0] disp_bcd;
    logic        disp_neg;
    logic        disp_sel;
    logic        busy;
    logic        overflow;

    modport master (
        output button_clr, button_ent, button_add, button_sub,
        output slider_1, slider_2, slider_3, slider_4,
        input  disp_bcd, disp_neg, disp_sel, busy, overflow
    );

    modport slave (
        input  button_clr, button_ent, button_add, button_sub,
        input  slider_1, slider_2, slider_3, slider_4,
        output disp_bcd, disp_neg, disp_sel, busy, overflow
    );
endinterface

// File: rtl/calculator_core.sv
// Four-digit BCD entry, clamped signed accumulator, and a 14-step double-dabble
// converter that turns |acc| into display digits.
module calculator_core #(
    parameter int ACC_MAX = 9999
) (
    input logic               clk,
    input logic               reset,
    calculator_core_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

    localparam logic [3:0]          LAST_ITER = 4'd13;
    localparam logic signed [17:0]  LIM_POS   = 18'(ACC_MAX);
    localparam logic signed [17:0]  LIM_NEG   = -18'(ACC_MAX);

    state_t              state_q, state_d;
    logic [3:0]          btn_q, btn_d;      // {sub, add, ent, clr}
    logic [15:0]         entry_q, entry_d;
    logic signed [15:0]  acc_q, acc_d;
    logic [29:0]         dd_q, dd_d;        // {bcd[15:0], binary[13:0]}
    logic [3:0]          iter_q, iter_d;
    logic [15:0]         disp_bcd_q, disp_bcd_d;
    logic                disp_neg_q, disp_neg_d;
    logic                disp_sel_q, disp_sel_d;
    logic                busy_q, busy_d;
    logic                overflow_q, overflow_d;

    logic [3:0]          btn_now, rise, sld;
    logic [15:0]         entry_inc, adj_bcd;
    logic [29:0]         dd_step;
    logic [13:0]         entry_val, mag;
    logic signed [17:0]  acc_ext, ent_ext, sum, clamped;
    logic                clamp_hit;

    assign btn_now = {bus.button_sub, bus.button_add, bus.button_ent, bus.button_clr};
    assign sld     = {bus.slider_4, bus.slider_3, bus.slider_2, bus.slider_1};
    assign rise    = btn_now & ~btn_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] ent_d;
            logic [3:0] bcd_d;
            assign ent_d = entry_q[gi*4 +: 4];
            assign entry_inc[gi*4 +: 4] = !sld[gi] ? ent_d :
                                          (ent_d == 4'd9) ? 4'd0 : ent_d + 4'd1;
            assign bcd_d = dd_q[14 + gi*4 +: 4];
            assign adj_bcd[gi*4 +: 4] = (bcd_d >= 4'd5) ? bcd_d + 4'd3 : bcd_d;
        end
    endgenerate

    assign dd_step   = {adj_bcd, dd_q[13:0]} << 1;
    assign entry_val = 14'(entry_q[15:12]) * 14'd1000 + 14'(entry_q[11:8]) * 14'd100
                     + 14'(entry_q[7:4]) * 14'd10 + 14'(entry_q[3:0]);
    assign acc_ext   = 18'(acc_q);
    assign ent_ext   = 18'(entry_val);
    // add outranks sub when both rise together
    assign sum       = rise[2] ? acc_ext + ent_ext : acc_ext - ent_ext;
    assign clamp_hit = (sum > LIM_POS) || (sum < LIM_NEG);
    assign clamped   = (sum > LIM_POS) ? LIM_POS : (sum < LIM_NEG) ? LIM_NEG : sum;
    assign mag       = clamped[17] ? 14'(-clamped) : 14'(clamped);

    always_comb begin
        state_d    = state_q;
        btn_d      = btn_now;
        entry_d    = entry_q;
        acc_d      = acc_q;
        dd_d       = dd_q;
        iter_d     = iter_q;
        disp_bcd_d = disp_bcd_q;
        disp_neg_d = disp_neg_q;
        disp_sel_d = disp_sel_q;
        busy_d     = busy_q;
        overflow_d = overflow_q;

        if (rise[0]) begin
            state_d    = IDLE;
            entry_d    = '0;
            acc_d      = '0;
            iter_d     = '0;
            disp_bcd_d = '0;
            disp_neg_d = 1'b0;
            disp_sel_d = 1'b0;
            busy_d     = 1'b0;
            overflow_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (rise[1]) begin
                entry_d    = entry_inc;
                disp_bcd_d = entry_inc;
                disp_neg_d = 1'b0;
                disp_sel_d = 1'b0;
            end else if (rise[2] || rise[3]) begin
                acc_d      = 16'(clamped);
                overflow_d = overflow_q | clamp_hit;
                entry_d    = '0;
                dd_d       = {16'd0, mag};
                iter_d     = '0;
                busy_d     = 1'b1;
                state_d    = CONV;
            end
        end else begin
            // Conversion in progress: ent/add/sub are dropped, display holds.
            dd_d   = dd_step;
            iter_d = iter_q + 4'd1;
            if (iter_q == LAST_ITER) begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                disp_bcd_d = dd_step[29:14];
                disp_neg_d = acc_q[15];
                disp_sel_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            btn_q      <= 4'hF;
            entry_q    <= '0;
            acc_q      <= '0;
            dd_q       <= '0;
            iter_q     <= '0;
            disp_bcd_q <= '0;
            disp_neg_q <= 1'b0;
            disp_sel_q <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_q      <= btn_d;
            entry_q    <= entry_d;
            acc_q      <= acc_d;
            dd_q       <= dd_d;
            iter_q     <= iter_d;
            disp_bcd_q <= disp_bcd_d;
            disp_neg_q <= disp_neg_d;
            disp_sel_q <= disp_sel_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.disp_bcd = disp_bcd_q;
    assign bus.disp_neg = disp_neg_q;
    assign bus.disp_sel = disp_sel_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_calculator_core.sv
// Calculator core bench: directed scenarios plus random button/slider traffic,
// all checked against an integer-arithmetic model of the calculator.
module tb_calculator_core;
    localparam int ACC_MAX = 9999;
    localparam logic [3:0] CLR = 4'b0001, ENT = 4'b0010, ADD = 4'b0100, SUB = 4'b1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] btn_drv = '0;   // {sub, add, ent, clr}
    logic [3:0] sld_drv = '0;   // slider_4..slider_1
    logic chk_en = 1'b0;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    calculator_core_if bus ();
    assign bus.button_clr = btn_drv[0];
    assign bus.button_ent = btn_drv[1];
    assign bus.button_add = btn_drv[2];
    assign bus.button_sub = btn_drv[3];
    assign bus.slider_1   = sld_drv[0];
    assign bus.slider_2   = sld_drv[1];
    assign bus.slider_3   = sld_drv[2];
    assign bus.slider_4   = sld_drv[3];

    calculator_core #(.ACC_MAX(ACC_MAX)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Behavioural model: decimal digits, integer accumulator, countdown for conversion.
    int m_dig[4];
    int m_acc, m_left;
    bit m_ovf, m_neg, m_sel, m_busy;
    logic [15:0] m_bcd;
    logic [3:0] m_prev;

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] entry_bcd();
        return {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] ev;
        int v, val;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
            m_acc = 0; m_left = 0; m_ovf = 0;
            m_bcd = '0; m_neg = 0; m_sel = 0; m_busy = 0;
            m_prev = 4'hF;
        end else begin
            ev = btn_drv & ~m_prev;
            m_prev = btn_drv;
            if (ev[0]) begin
                for (int i = 0; i < 4; i++) m_dig[i] = 0;
                m_acc = 0; m_left = 0; m_ovf = 0;
                m_bcd = '0; m_neg = 0; m_sel = 0; m_busy = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_bcd  = to_bcd(m_acc < 0 ? -m_acc : m_acc);
                    m_neg  = (m_acc < 0);
                    m_sel  = 1;
                end
            end else if (ev[1]) begin
                for (int i = 0; i < 4; i++)
                    if (sld_drv[i]) m_dig[i] = (m_dig[i] + 1) % 10;
                m_bcd = entry_bcd(); m_neg = 0; m_sel = 0;
            end else if (ev[2] || ev[3]) begin
                val = m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
                v = ev[2] ? m_acc + val : m_acc - val;
                if (v > ACC_MAX) begin v = ACC_MAX; m_ovf = 1; end
                else if (v < -ACC_MAX) begin v = -ACC_MAX; m_ovf = 1; end
                m_acc = v;
                for (int i = 0; i < 4; i++) m_dig[i] = 0;
                m_left = 14;
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ({bus.disp_bcd, bus.disp_neg, bus.disp_sel, bus.busy, bus.overflow}
                !== {m_bcd, m_neg, m_sel, m_busy, m_ovf}) begin
                n_fail++;
                $display("FAIL model t=%0t got bcd=%h neg=%b sel=%b busy=%b ovf=%b need bcd=%h neg=%b sel=%b busy=%b ovf=%b",
                         $time, bus.disp_bcd, bus.disp_neg, bus.disp_sel, bus.busy, bus.overflow,
                         m_bcd, m_neg, m_sel, m_busy, m_ovf);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(logic [3:0] m);
        btn_drv = m; tick(1);
        btn_drv = '0; tick(1);
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h need %h", name, got, exp);
        end else begin
            $display("check %s: %h", name, got);
        end
    endtask

    // Pulse an arithmetic button, then count busy cycles until the conversion ends.
    task automatic arith(logic [3:0] m, output int n);
        btn_drv = m; tick(1);
        btn_drv = '0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            tick(1);
        end
        if (n >= 40) check("busy_timeout", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        btn_drv = ENT;          // held through reset
        sld_drv = 4'b0101;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        check("rst_bcd", 32'(bus.disp_bcd), 32'h0);
        check("rst_flags", {28'd0, bus.disp_neg, bus.disp_sel, bus.busy, bus.overflow}, 32'd0);
        btn_drv = '0; tick(2);
        check("held_no_event", 32'(bus.disp_bcd), 32'h0);

        repeat (3) press(ENT);
        check("entry_0303", {15'd0, bus.disp_sel, bus.disp_bcd}, 32'h0303);
        repeat (7) press(ENT);
        check("entry_wrap", 32'(bus.disp_bcd), 32'h0000);

        repeat (3) press(ENT);
        arith(ADD, n);
        check("busy_len", 32'(n), 32'd14);
        check("add_0303", {14'd0, bus.disp_neg, bus.disp_sel, bus.disp_bcd}, 32'h1_0303);

        sld_drv = 4'b0100;
        repeat (5) press(ENT);
        check("entry_0500", 32'(bus.disp_bcd), 32'h0500);
        arith(SUB, n);
        check("sub_neg197", {14'd0, bus.disp_neg, bus.disp_sel, bus.disp_bcd}, 32'h3_0197);

        press(CLR);
        check("clr_bcd", {14'd0, bus.disp_neg, bus.disp_sel, bus.disp_bcd}, 32'h0);

        sld_drv = 4'b1111;
        repeat (9) press(ENT);
        arith(ADD, n);
        check("add_9999", {15'd0, bus.overflow, bus.disp_bcd}, 32'h0_9999);
        repeat (9) press(ENT);
        arith(ADD, n);
        check("ovf_9999", {15'd0, bus.overflow, bus.disp_bcd}, 32'h1_9999);
        press(CLR);
        check("ovf_clr", {15'd0, bus.overflow, bus.disp_bcd}, 32'h0);

        sld_drv = 4'b0001;
        press(ENT);
        btn_drv = CLR | ADD; tick(1); btn_drv = '0;
        check("clr_add_busy", 32'(bus.busy), 32'd0);
        check("clr_add_bcd", {15'd0, bus.disp_sel, bus.disp_bcd}, 32'h0);
        tick(1);
        press(ENT);
        arith(ADD | SUB, n);
        check("add_sub_prio", {14'd0, bus.disp_neg, bus.disp_sel, bus.disp_bcd}, 32'h1_0001);

        repeat (2) press(ENT);
        btn_drv = ADD; tick(1);
        btn_drv = ENT; tick(1);
        btn_drv = '0;  tick(1);
        btn_drv = ADD; tick(1);
        check("conv_hold", {14'd0, bus.busy, bus.disp_sel, bus.disp_bcd}, 32'h2_0002);
        btn_drv = CLR; tick(1); btn_drv = '0;
        check("abort_clr", {14'd0, bus.busy, bus.disp_sel, bus.disp_bcd}, 32'h0);
        tick(1);

        repeat (3) press(ENT);
        btn_drv = ADD; tick(1); btn_drv = '0; tick(3);
        reset = 1'b1; tick(1);
        check("abort_rst", {14'd0, bus.busy, bus.disp_sel, bus.disp_bcd}, 32'h0);
        reset = 1'b0; tick(1);

        repeat (3000) begin
            btn_drv[0] = ($urandom_range(0, 39) == 0);
            for (int i = 1; i < 4; i++) btn_drv[i] = ($urandom_range(0, 3) == 0);
            sld_drv = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        reset = 1'b0; btn_drv = '0;
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/calculator_core.md
CALCULATOR_CORE -- requirements
Module: calculator_core

Interface
REQ-001 Parameter: ACC_MAX, default 9999, magnitude clamp for the accumulator (decimal, at most 9999).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 button_clr, button_ent, button_add, button_sub  in  1 each  synchronized, debounced button levels.
REQ-006 slider_1, slider_2, slider_3, slider_4  in  1 each  synchronized, debounced slider levels; slider_1 selects the ones digit, slider_4 the thousands digit.
REQ-007 disp_bcd  out  16  four BCD digits for the display mux; [3:0] is the ones digit, [15:12] is the thousands digit.
REQ-008 disp_neg  out  1  sign of the displayed value (1 = negative).
REQ-009 disp_sel  out  1  0 = entry view, 1 = result view.
REQ-010 busy  out  1  high while a binary-to-BCD conversion runs.
REQ-011 overflow  out  1  sticky flag, set on an accumulator clamp.

Function
REQ-012 Button events: each button level is registered; an event is a 0->1 transition of that level; each press produces exactly one event.
REQ-013 Simultaneous events in one cycle: priority is clr > ent > add > sub; lower-priority events in that cycle are discarded.
REQ-014 Entry register: four BCD digits, reset 0000.
- Each ent event increments by 1 every digit whose slider is high.
- Digits wrap 9->0 with no carry between digits.
- ent with all sliders low changes nothing.
REQ-015 Accumulator: signed binary, at least 15 bits, reset 0.
- add: acc <= acc + entry.
- sub: acc <= acc - entry.
- entry value = d3*1000 + d2*100 + d1*10 + d0.
REQ-016 Clamp: if the add/sub result is above +ACC_MAX or below -ACC_MAX, acc takes the limit of matching sign and overflow is set; overflow clears only on clr or reset.
REQ-017 After an add or sub event: entry is cleared to 0000 in the same cycle acc updates, and a conversion of |acc| starts.
REQ-018 FSM states: IDLE and CONV.
- IDLE -> CONV on an add or sub event.
- CONV -> IDLE after 14 shift-add-3 iterations (double-dabble) on |acc|.
- CONV -> IDLE immediately on a clr event.
REQ-019 Conversion timing:
- busy rises on the edge after the cycle that detects the event.
- busy stays high for exactly 14 cycles.
- When busy falls: disp_bcd = BCD of |acc|, disp_neg = acc<0, disp_sel = 1, all on that same edge.
REQ-020 During CONV: ent, add and sub events are ignored (dropped, not queued); disp_* hold their previous values.
REQ-021 ent event in IDLE: on the next edge, disp_bcd = new entry, disp_neg = 0, disp_sel = 0.
REQ-022 clr event (any state):
- entry = 0000, acc = 0, overflow = 0, busy = 0.
- disp_bcd = 0000, disp_neg = 0, disp_sel = 0.
- Takes effect on the next edge.
REQ-023 A result of exactly 0 displays as 0000 with disp_neg = 0; a negative zero is never shown.
REQ-024 Outputs are registered; no combinational path runs from any input to any output.

Reset
REQ-025 With reset high at a clock edge:
- state = IDLE, entry = 0000, acc = 0.
- disp_bcd = 0000, disp_neg = 0, disp_sel = 0, busy = 0, overflow = 0.
REQ-026 The registered button levels reset to 1, so a button held through reset generates no event until it is released and pressed again.
REQ-027 Reset during CONV aborts the conversion with no partial display update.

Verification
REQ-028 Reset: after reset -> disp_bcd = 0000, disp_neg = 0, disp_sel = 0, busy = 0, overflow = 0; a button held through reset produces no event.
REQ-029 Entry: slider_1 and slider_3 high, 3 ent presses -> disp_bcd = 0303, disp_sel = 0; 7 further presses -> digits wrap to 0000.
REQ-030 Arithmetic, add then subtract:
- Entry 0303, add -> busy high for exactly 14 cycles, then disp_bcd = 0303, disp_sel = 1.
- Then entry 0500, sub -> disp_bcd = 0197, disp_neg = 1.
REQ-031 Overflow: entry 9999, add twice -> disp_bcd = 9999, overflow = 1; then clr -> 0000, overflow = 0.
REQ-032 Simultaneous events: clr and add rising in the same cycle -> clr effect only, busy stays 0; add and sub in the same cycle -> add only.
REQ-033 Abort: add, then reset (or clr) at cycle 5 of CONV -> busy = 0 next edge, disp_bcd = 0000, disp_sel = 0; ent/add presses during CONV change nothing.
